pmem_line_responder: RTL and testbench
======================================

Name: pmem_line_responder

Overview:
- Responder end of the 256-bit line interface that the L1 cache drives: pmem_read/pmem_write/pmem_address/pmem_wdata in; pmem_resp/pmem_rdata out.
- Holds a line-granular backing store and services one request at a time with a fixed, parameterised latency.
- Sits below the cache in the memory hierarchy. It serves as the synthesizable main-memory stand-in for both integration and FPGA builds.

Parameters:
- LINE_IDX_BITS, 8, log2 of the number of 256-bit lines stored; default is 256 lines = 8 KiB.
- READ_LATENCY, 12, cycles from request capture to the pmem_resp cycle for reads; legal range 1..255.
- WRITE_LATENCY, 12, cycles from request capture to the pmem_resp cycle for writes; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pmem_read  in  1  line read request; held by the initiator until pmem_resp.
- pmem_write  in  1  line write request; held by the initiator until pmem_resp.
- pmem_address  in  32  byte address; bits [4:0] ignored; line index = [LINE_IDX_BITS+4:5]; higher bits ignored (aliasing).
- pmem_wdata  in  256  write line; bit 0 = byte 0 of the line.
- pmem_resp  out  1  single-cycle completion strobe.
- pmem_rdata  out  256  read line; valid only in the pmem_resp cycle of a read.
- protocol_err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values: pmem_resp=0, pmem_rdata=0, protocol_err=0, state=IDLE, counter=0. The line array itself is not reset.
- States are IDLE, BUSY, RESP.
- IDLE:
  - If pmem_read|pmem_write, capture op, line index and wdata; load counter with LATENCY-1; go to BUSY, or straight to RESP when LATENCY==1.
  - If both pmem_read and pmem_write are high, set protocol_err and service the request as a write.
- BUSY:
  - Decrement the counter each cycle; go to RESP when counter==0.
  - Read: the array is read using the captured index; pmem_rdata is registered so it is stable in the RESP cycle.
- RESP:
  - pmem_resp=1 for exactly one cycle.
  - Write: the captured wdata is committed to the array on the clock edge ending RESP.
  - Next state is IDLE unconditionally.
- Latency: request sampled at edge 0 → pmem_resp high during cycle LATENCY (edges counted from capture). Total occupancy is LATENCY+1 cycles including the capture cycle.
- Back-to-back requests:
  - The cycle after RESP is IDLE, and a request present there is captured. This covers the writeback-then-fill sequence of a dirty miss: the write completes, then the read is issued.
  - No request is accepted while in BUSY or RESP.
- Initiator stability:
  - In BUSY, if op, address[LINE_IDX_BITS+4:5] or wdata differ from the captured values, or the request drops to 0, set protocol_err.
  - The transaction still completes using the captured values.
- pmem_rdata outside the read RESP cycle holds its last value (don't-care to the initiator). It is never X after reset.
- Reset mid-operation:
  - Asynchronous return to IDLE; pmem_resp deasserts immediately.
  - An uncommitted write is dropped and array contents are otherwise preserved.
- Read-after-write to the same line returns the new data, because the write commits before the following IDLE cycle.

Decomposition:
- Package pmem_types:
  - LINE_BITS=256, OFFSET_BITS=5.
  - typedef pmem_line_t (logic [255:0]).
  - enum pmem_resp_state_t {IDLE, BUSY, RESP}.
- Sub-module pmem_line_array:
  - Single-port 2^LINE_IDX_BITS × 256 storage with synchronous write and registered read.
  - Inferable as block RAM.
- The FSM, latency counter and error checker live in pmem_line_responder.

Test Plan:
- Write then read, with LATENCY=12:
  - Write addr 0x0000_0040, wdata {8{32'hDEAD_BEEF}} → pmem_resp exactly 12 cycles after capture, for 1 cycle.
  - Read of addr 0x0000_0040 → pmem_rdata = {8{32'hDEAD_BEEF}} in its resp cycle.
- Offset and alias: write line at 0x0000_0020, read 0x0000_003C → same data. With LINE_IDX_BITS=8, read 0x0000_2020 → same data (alias).
- Back-to-back dirty-miss pattern:
  - Write 0x100 followed immediately in the IDLE cycle by read 0x200 (preloaded pattern A) → two resp pulses 13 cycles apart.
  - The read returns A; protocol_err stays 0.
- Protocol violations:
  - Assert read and write together → protocol_err=1 and a write is performed.
  - Change pmem_address during BUSY → the original line is serviced and protocol_err stays 1 until rst.
- Reset mid-write: assert rst at cycle 5 of a write to 0x80 holding old value X → pmem_resp=0 immediately; a later read of 0x80 returns X.
- LATENCY=1 configuration: a read request → pmem_resp in the cycle right after capture. 4 consecutive reads → one resp every 2 cycles.

Source files
------------

// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the 256-bit line memory responder.
package pmem_types;
  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_BITS    = 8;

  typedef logic [LINE_BITS-1:0] pmem_line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_resp_state_t;
endpackage

// File: rtl/pmem_line_responder_if.sv
// Cache-to-memory line interface: the cache is the master, the memory is the slave.
interface pmem_line_responder_if;
  import pmem_types::*;

  // Handshake: the master raises pmem_read or pmem_write with a stable address and
  // wdata and holds them until it sees pmem_resp; pmem_resp is a one-cycle strobe
  // that completes the request, and pmem_rdata is meaningful only in that cycle.
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  pmem_line_t  pmem_wdata;
  logic        pmem_resp;
  pmem_line_t  pmem_rdata;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_line_array.sv
// Single-port line storage with synchronous write and registered read (block-RAM style).
module pmem_line_array
  import pmem_types::*;
#(
  parameter int IDX_BITS = 8
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_BITS-1:0] addr,
  input  pmem_line_t          wdata,
  output pmem_line_t          q
);
  pmem_line_t mem [2**IDX_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) q <= mem[addr];
  end
endmodule

// File: rtl/pmem_line_responder.sv
// Main-memory stand-in: one line request at a time, fixed read/write latency, sticky
// protocol error flag for initiator misbehaviour.
module pmem_line_responder
  import pmem_types::*;
#(
  parameter int LINE_IDX_BITS = 8,
  parameter int READ_LATENCY  = 12,
  parameter int WRITE_LATENCY = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  pmem_line_responder_if.slave  bus,
  output logic                  protocol_err,
  output pmem_resp_state_t      state_dbg
);
  localparam int IDX_LSB = OFFSET_BITS;
  localparam int IDX_MSB = LINE_IDX_BITS + OFFSET_BITS - 1;

  pmem_resp_state_t         state, next_state;
  logic [CNT_BITS-1:0]      cnt, in_lat;
  logic                     cap_read, cap_write;
  logic [LINE_IDX_BITS-1:0] cap_idx, in_idx, arr_addr;
  pmem_line_t               cap_wdata, arr_q;
  logic                     req, in_direct, busy_done, mismatch;
  logic                     arr_we, arr_re, rdata_valid;
  logic                     addr_unused;

  assign in_idx      = bus.pmem_address[IDX_MSB:IDX_LSB];
  assign addr_unused = ^{bus.pmem_address[31:IDX_MSB+1], bus.pmem_address[IDX_LSB-1:0]};
  assign req         = bus.pmem_read | bus.pmem_write;
  // A simultaneous read+write is serviced as a write, so it takes the write latency.
  assign in_lat      = bus.pmem_write ? CNT_BITS'(WRITE_LATENCY) : CNT_BITS'(READ_LATENCY);
  assign in_direct   = (in_lat == CNT_BITS'(1));
  assign busy_done   = (cnt == CNT_BITS'(1));
  assign mismatch    = (bus.pmem_read != cap_read) || (bus.pmem_write != cap_write) ||
                       (in_idx != cap_idx) || (bus.pmem_wdata != cap_wdata);
  assign state_dbg   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = in_direct ? RESP : BUSY;
      BUSY:    if (busy_done) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The array address follows the bus in IDLE so a latency-1 read can fetch at capture.
  always_comb begin
    bus.pmem_resp = 1'b0;
    arr_we        = 1'b0;
    arr_re        = 1'b0;
    arr_addr      = cap_idx;
    case (state)
      IDLE: begin
        arr_addr = in_idx;
        arr_re   = req && !bus.pmem_write && in_direct;
      end
      BUSY: arr_re = busy_done && !cap_write;
      RESP: begin
        bus.pmem_resp = 1'b1;
        arr_we        = cap_write;
      end
      default: ;
    endcase
  end

  // Counter holds LATENCY-1 at capture; BUSY lasts until it decrements to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cap_read  <= 1'b0;
      cap_write <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          cnt       <= in_lat - CNT_BITS'(1);
          cap_read  <= bus.pmem_read;
          cap_write <= bus.pmem_write;
          cap_idx   <= in_idx;
          cap_wdata <= bus.pmem_wdata;
        end
        BUSY:    cnt <= cnt - CNT_BITS'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      protocol_err <= 1'b0;
    end else if ((state == IDLE && bus.pmem_read && bus.pmem_write) ||
                 (state == BUSY && mismatch)) begin
      protocol_err <= 1'b1;
    end
  end

  // The array output register has no reset; mask it until it has been loaded once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rdata_valid <= 1'b0;
    else if (arr_re) rdata_valid <= 1'b1;
  end

  assign bus.pmem_rdata = rdata_valid ? arr_q : '0;

  pmem_line_array #(.IDX_BITS(LINE_IDX_BITS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (cap_wdata),
    .q     (arr_q)
  );
endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: directed scenarios plus randomized traffic against a line-store model.
module tb_pmem_line_responder;
  import pmem_types::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_line_responder_if bus0();
  pmem_line_responder_if bus1();
  logic             err0, err1;
  pmem_resp_state_t st0, st1;

  pmem_line_responder #(.LINE_IDX_BITS(8), .READ_LATENCY(12), .WRITE_LATENCY(12)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .protocol_err(err0), .state_dbg(st0));

  pmem_line_responder #(.LINE_IDX_BITS(8), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .protocol_err(err1), .state_dbg(st1));

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  pmem_line_t model0 [int];
  pmem_line_t model1 [int];
  logic [LINE_BITS-1:0] exp_q [$];

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % 256);
  endfunction

  function automatic pmem_line_t rand_line();
    pmem_line_t l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int w, input logic rd, input logic wr,
                       input logic [31:0] a, input pmem_line_t wd);
    if (w == 0) begin
      bus0.pmem_read = rd; bus0.pmem_write = wr; bus0.pmem_address = a; bus0.pmem_wdata = wd;
    end else begin
      bus1.pmem_read = rd; bus1.pmem_write = wr; bus1.pmem_address = a; bus1.pmem_wdata = wd;
    end
  endtask

  function automatic logic resp_of(input int w);
    return (w == 0) ? bus0.pmem_resp : bus1.pmem_resp;
  endfunction

  function automatic pmem_line_t rdata_of(input int w);
    return (w == 0) ? bus0.pmem_rdata : bus1.pmem_rdata;
  endfunction

  // Called at a negedge; returns at the negedge of the response cycle with the request still held.
  task automatic txn(input int w, input string tag, input logic rd, input logic wr,
                     input logic [31:0] a, input pmem_line_t wd, input int exp_k,
                     input int perturb_at, input logic [31:0] perturb_addr);
    int k;
    bit got;
    int idx;
    k   = 0;
    got = 1'b0;
    idx = line_of(a);
    if (!wr) exp_q.push_back((w == 0) ? model0[idx] : model1[idx]);
    drive(w, rd, wr, a, wd);
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == perturb_at) drive(w, rd, wr, perturb_addr, wd);
      if (resp_of(w)) got = 1'b1;
    end
    chk($sformatf("%s resp_cycle", tag), 256'(k), 256'(exp_k));
    if (!wr) begin
      logic [255:0] e;
      e = exp_q.pop_front();
      if (got) chk($sformatf("%s rdata", tag), rdata_of(w), e);
    end else if (got) begin
      if (w == 0) model0[idx] = wd;
      else        model1[idx] = wd;
    end
  endtask

  task automatic finish_idle(input int w, input string tag);
    drive(w, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    chk($sformatf("%s resp_one_cycle", tag), 256'(resp_of(w)), 256'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pmem_line_t a_pat, w_pat, d_pat, x_pat, y_pat;
    logic [31:0] ra;
    logic        rwr;
    logic        err0_exp;
    int          k;
    bit          got;

    drive(0, 1'b0, 1'b0, 32'h0, '0);
    drive(1, 1'b0, 1'b0, 32'h0, '0);
    err0_exp = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset resp", 256'(bus0.pmem_resp), 256'(0));
    chk("reset rdata", bus0.pmem_rdata, '0);
    chk("reset err", 256'(err0), 256'(0));
    chk("reset state", {254'b0, st0}, {254'b0, IDLE});
    rst = 1'b0;
    @(negedge clk);

    // Write then read
    txn(0, "wr40", 1'b0, 1'b1, 32'h0000_0040, {8{32'hDEAD_BEEF}}, 12, 0, 32'h0);
    finish_idle(0, "wr40");
    txn(0, "rd40", 1'b1, 1'b0, 32'h0000_0040, '0, 12, 0, 32'h0);
    chk("rd40 literal", bus0.pmem_rdata, {8{32'hDEAD_BEEF}});
    finish_idle(0, "rd40");

    // Offset bits ignored, high bits alias
    a_pat = rand_line();
    txn(0, "wr20", 1'b0, 1'b1, 32'h0000_0020, a_pat, 12, 0, 32'h0);
    finish_idle(0, "wr20");
    txn(0, "rd3c", 1'b1, 1'b0, 32'h0000_003C, '0, 12, 0, 32'h0);
    finish_idle(0, "rd3c");
    txn(0, "rd2020", 1'b1, 1'b0, 32'h0000_2020, '0, 12, 0, 32'h0);
    chk("alias literal", bus0.pmem_rdata, a_pat);
    finish_idle(0, "rd2020");

    // Dirty-miss: write then read captured in the immediately following IDLE cycle
    a_pat = rand_line();
    w_pat = rand_line();
    txn(0, "pre200", 1'b0, 1'b1, 32'h0000_0200, a_pat, 12, 0, 32'h0);
    finish_idle(0, "pre200");
    txn(0, "wb100", 1'b0, 1'b1, 32'h0000_0100, w_pat, 12, 0, 32'h0);
    txn(0, "fill200", 1'b1, 1'b0, 32'h0000_0200, '0, 13, 0, 32'h0);
    finish_idle(0, "fill200");
    chk("dirty miss err", 256'(err0), 256'(err0_exp));

    // Randomized traffic over lines 0..7 with random offsets and alias bits
    for (int i = 0; i < 8; i++) begin
      txn(0, "preload", 1'b0, 1'b1, 32'(i * 32), rand_line(), 12, 0, 32'h0);
      finish_idle(0, "preload");
    end
    k = 12;
    for (int i = 0; i < 16; i++) begin
      ra  = {19'($urandom()), 8'($urandom_range(0, 7)), 5'($urandom())};
      rwr = 1'($urandom_range(0, 1));
      txn(0, $sformatf("rand%0d", i), !rwr, rwr, ra, rand_line(), k, 0, 32'h0);
      if ($urandom_range(0, 1) == 0) begin
        finish_idle(0, "rand");
        k = 12;
      end else begin
        k = 13;
      end
    end
    finish_idle(0, "rand_end");
    chk("rand err", 256'(err0), 256'(err0_exp));

    // Read and write together: flagged, serviced as a write
    d_pat = rand_line();
    txn(0, "rdwr300", 1'b1, 1'b1, 32'h0000_0300, d_pat, 12, 0, 32'h0);
    finish_idle(0, "rdwr300");
    err0_exp = 1'b1;
    chk("rdwr err", 256'(err0), 256'(err0_exp));
    txn(0, "rd300", 1'b1, 1'b0, 32'h0000_0300, '0, 12, 0, 32'h0);
    finish_idle(0, "rd300");

    // Address changes during BUSY: original line still serviced
    txn(0, "rd40pert", 1'b1, 1'b0, 32'h0000_0040, '0, 12, 4, 32'h0000_0060);
    finish_idle(0, "rd40pert");
    repeat (3) @(negedge clk);
    chk("sticky err", 256'(err0), 256'(err0_exp));

    // Reset at cycle 5 of a write: old line contents survive
    x_pat = rand_line();
    y_pat = rand_line();
    txn(0, "wr80x", 1'b0, 1'b1, 32'h0000_0080, x_pat, 12, 0, 32'h0);
    finish_idle(0, "wr80x");
    drive(0, 1'b0, 1'b1, 32'h0000_0080, y_pat);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst mid resp", 256'(bus0.pmem_resp), 256'(0));
    chk("rst mid state", {254'b0, st0}, {254'b0, IDLE});
    err0_exp = 1'b0;
    chk("rst clears err", 256'(err0), 256'(err0_exp));
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(0, "rd80a", 1'b1, 1'b0, 32'h0000_0080, '0, 12, 0, 32'h0);
    finish_idle(0, "rd80a");

    // Reset inside the RESP cycle of a write: pulse drops at once and the write is lost
    drive(0, 1'b0, 1'b1, 32'h0000_0080, y_pat);
    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (bus0.pmem_resp) got = 1'b1;
    end
    chk("wr80y resp_cycle", 256'(k), 256'(12));
    #1 rst = 1'b1;
    #1;
    chk("rst in resp", 256'(bus0.pmem_resp), 256'(0));
    drive(0, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    txn(0, "rd80b", 1'b1, 1'b0, 32'h0000_0080, '0, 12, 0, 32'h0);
    chk("rd80b literal", bus0.pmem_rdata, x_pat);
    finish_idle(0, "rd80b");

    // Latency-1 instance
    for (int i = 0; i < 4; i++) begin
      txn(1, "l1_wr", 1'b0, 1'b1, 32'(32'h400 + i * 32), rand_line(), 1, 0, 32'h0);
      finish_idle(1, "l1_wr");
    end
    txn(1, "l1_rd0", 1'b1, 1'b0, 32'h0000_0400, '0, 1, 0, 32'h0);
    for (int i = 1; i < 4; i++)
      txn(1, $sformatf("l1_rd%0d", i), 1'b1, 1'b0, 32'(32'h400 + i * 32), '0, 2, 0, 32'h0);
    finish_idle(1, "l1_rd");
    chk("l1 err", 256'(err1), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
